fib_index: RTL and testbench



---
 rtl/fib_index.sv | 147 ++++++++++++++
 tb/tb_fib_index.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fib_index.sv
// fib_index: inverse Fibonacci decoder.
//
// Accepts a value V on an Avalon-ST sink and returns the index n such that
// F(n) == V, with F(1) = F(2) = 1. Terms are generated one per clock and
// compared against V, so only one request is in flight at a time. When V
// is not a Fibonacci number, the index of the largest term below V is
// returned together with ASO_ERROR. The search stops at IDX_MAX, so the
// term registers can never overflow.
//
// Ports:
//   CLK        rising-edge clock
//   RESET_n    synchronous active-low reset
//   ASI_READY  sink ready, high only while idle
//   ASI_VALID  sink data valid
//   ASI_DATA   value V to decode
//   ASO_VALID  one-cycle result strobe
//   ASO_DATA   result index, zero-extended to DATA_W
//   ASO_ERROR  V is not a Fibonacci number (qualified by ASO_VALID)
module fib_index #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned IDX_MAX = 47
) (
  input  logic              CLK,
  input  logic              RESET_n,
  output logic              ASI_READY,
  input  logic              ASI_VALID,
  input  logic [DATA_W-1:0] ASI_DATA,
  output logic              ASO_VALID,
  output logic [DATA_W-1:0] ASO_DATA,
  output logic              ASO_ERROR
);

  localparam int unsigned IDX_W = $clog2(IDX_MAX + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(IDX_MAX);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               ready_q, ready_d;
  logic [DATA_W-1:0]  val_q,   val_d;
  logic [DATA_W-1:0]  prev_q,  prev_d;
  logic [DATA_W-1:0]  cur_q,   cur_d;
  logic [IDX_W-1:0]   idx_q,   idx_d;
  logic               ovld_q,  ovld_d;
  logic [DATA_W-1:0]  odata_q, odata_d;
  logic               oerr_q,  oerr_d;

  assign ASI_READY = ready_q;
  assign ASO_VALID = ovld_q;
  assign ASO_DATA  = odata_q;
  assign ASO_ERROR = oerr_q;

  always_comb begin
    state_d = state_q;
    ready_d = ready_q;
    val_d   = val_q;
    prev_d  = prev_q;
    cur_d   = cur_q;
    idx_d   = idx_q;
    ovld_d  = ovld_q;
    odata_d = odata_q;
    oerr_d  = oerr_q;

    case (state_q)
      S_IDLE: begin
        // Ready comes up one edge after reset release (or after DONE);
        // an accept needs the registered ready to already be high.
        ready_d = 1'b1;
        if (ready_q && ASI_VALID) begin
          val_d   = ASI_DATA;
          prev_d  = '0;
          cur_d   = DATA_W'(1);
          idx_d   = IDX_W'(1);
          ready_d = 1'b0;
          state_d = S_CALC;
        end
      end

      S_CALC: begin
        // Equality is tested first so V=1 resolves at index 1, never 2.
        if (cur_q == val_q) begin
          odata_d = DATA_W'(idx_q);
          oerr_d  = 1'b0;
          ovld_d  = 1'b1;
          state_d = S_DONE;
        end else if (cur_q > val_q) begin
          // Overshot: V lies strictly between two terms (or V is 0).
          odata_d = DATA_W'(idx_q - IDX_W'(1));
          oerr_d  = 1'b1;
          ovld_d  = 1'b1;
          state_d = S_DONE;
        end else if (idx_q == IDX_LAST) begin
          // V exceeds the largest representable term.
          odata_d = DATA_W'(IDX_LAST);
          oerr_d  = 1'b1;
          ovld_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          prev_d = cur_q;
          cur_d  = prev_q + cur_q;
          idx_d  = idx_q + IDX_W'(1);
        end
      end

      S_DONE: begin
        ovld_d  = 1'b0;
        ready_d = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        ready_d = 1'b0;
        ovld_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET_n) begin
      state_q <= S_IDLE;
      ready_q <= 1'b0;
      val_q   <= '0;
      prev_q  <= '0;
      cur_q   <= '0;
      idx_q   <= '0;
      ovld_q  <= 1'b0;
      odata_q <= '0;
      oerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      val_q   <= val_d;
      prev_q  <= prev_d;
      cur_q   <= cur_d;
      idx_q   <= idx_d;
      ovld_q  <= ovld_d;
      odata_q <= odata_d;
      oerr_q  <= oerr_d;
    end
  end

endmodule

// File: tb/tb_fib_index.sv
// Testbench for fib_index: scoreboard of expected results, one task per
// scenario, each comparing DUT observations against queued expectations.
module tb_fib_index;

  logic        CLK;
  logic        RESET_n;
  logic        ASI_READY;
  logic        ASI_VALID;
  logic [31:0] ASI_DATA;
  logic        ASO_VALID;
  logic [31:0] ASO_DATA;
  logic        ASO_ERROR;

  fib_index #(.DATA_W(32), .IDX_MAX(47)) dut (
    .CLK       (CLK),
    .RESET_n   (RESET_n),
    .ASI_READY (ASI_READY),
    .ASI_VALID (ASI_VALID),
    .ASI_DATA  (ASI_DATA),
    .ASO_VALID (ASO_VALID),
    .ASO_DATA  (ASO_DATA),
    .ASO_ERROR (ASO_ERROR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          checks   = 0;
  int          failures = 0;
  logic [63:0] fib_tab[0:48];

  // Observations from one request.
  int          o_wait, o_lat;
  logic [31:0] o_data, o_nxt_data;
  logic        o_err, o_nxt_valid, o_nxt_ready, o_rdy_seen;

  // Expected result from the Fibonacci table: largest index whose term
  // does not exceed v, with V=1 mapped to index 1.
  function automatic exp_t model(input logic [63:0] v);
    exp_t r;
    int   m;
    if (v == 0) begin
      r.data = 32'd0; r.err = 1'b1; r.lat = 1;
      return r;
    end
    if (v == 1) begin
      r.data = 32'd1; r.err = 1'b0; r.lat = 1;
      return r;
    end
    m = 1;
    for (int n = 1; n <= 47; n++)
      if (fib_tab[n] <= v) m = n;
    if (fib_tab[m] == v) begin
      r.data = 32'(m); r.err = 1'b0; r.lat = m;
    end else if (m == 47) begin
      r.data = 32'd47; r.err = 1'b1; r.lat = 47;
    end else begin
      r.data = 32'(m); r.err = 1'b1; r.lat = m + 1;
    end
    return r;
  endfunction

  // Drives one request and records what the DUT does; performs no checks.
  task automatic run_req(input logic [31:0] v, input bit hold, input logic [31:0] junk);
    o_wait = 0;
    o_rdy_seen = 1'b0;
    @(negedge CLK);
    while (ASI_READY !== 1'b1 && o_wait < 100) begin
      @(negedge CLK);
      o_wait++;
    end
    ASI_VALID = 1'b1;
    ASI_DATA  = v;
    @(posedge CLK);
    #1;
    if (hold) ASI_DATA = junk;
    else ASI_VALID = 1'b0;
    o_lat = 0;
    begin : wait_res
      while (o_lat < 60) begin
        @(posedge CLK);
        o_lat++;
        #1;
        if (ASI_READY === 1'b1) o_rdy_seen = 1'b1;
        if (ASO_VALID === 1'b1) disable wait_res;
      end
      o_lat = -1;
    end
    o_data = ASO_DATA;
    o_err  = ASO_ERROR;
    ASI_VALID = 1'b0;
    @(posedge CLK);
    #1;
    o_nxt_valid = ASO_VALID;
    o_nxt_ready = ASI_READY;
    o_nxt_data  = ASO_DATA;
  endtask

  task automatic test_reset;
    RESET_n = 1'b0; ASI_VALID = 1'b0; ASI_DATA = '0;
    repeat (2) @(posedge CLK);
    #1;
    checks++; if (ASI_READY !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", ASI_READY); end
    checks++; if (ASO_VALID !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", ASO_VALID); end
    checks++; if (ASO_DATA !== 32'd0) begin failures++; $display("FAIL reset_data got=%0d exp=0", ASO_DATA); end
    checks++; if (ASO_ERROR !== 1'b0) begin failures++; $display("FAIL reset_error got=%b exp=0", ASO_ERROR); end
    @(negedge CLK); RESET_n = 1'b1;
    @(posedge CLK); #1;
    checks++; if (ASI_READY !== 1'b1) begin failures++; $display("FAIL reset_ready_rise got=%b exp=1", ASI_READY); end
  endtask

  task automatic test_one;
    exp_t e;
    sb.push_back('{data: 32'd1, err: 1'b0, lat: 1});
    run_req(32'd1, 1'b0, 32'd0);
    e = sb.pop_front();
    checks++; if (o_data !== e.data) begin failures++; $display("FAIL one_data got=%0d exp=%0d", o_data, e.data); end
    checks++; if (o_err !== e.err) begin failures++; $display("FAIL one_err got=%b exp=%b", o_err, e.err); end
    checks++; if (o_lat !== e.lat) begin failures++; $display("FAIL one_lat got=%0d exp=%0d", o_lat, e.lat); end
    checks++; if (o_nxt_valid !== 1'b0) begin failures++; $display("FAIL one_pulse got=%b exp=0", o_nxt_valid); end
    checks++; if (o_nxt_ready !== 1'b1) begin failures++; $display("FAIL one_ready got=%b exp=1", o_nxt_ready); end
    checks++; if (o_nxt_data !== e.data) begin failures++; $display("FAIL one_hold got=%0d exp=%0d", o_nxt_data, e.data); end
  endtask

  task automatic test_sweep;
    exp_t e;
    for (int n = 3; n <= 47; n++) begin
      sb.push_back('{data: 32'(n), err: 1'b0, lat: n});
      run_req(fib_tab[n][31:0], 1'b0, 32'd0);
      e = sb.pop_front();
      checks++; if (o_data !== e.data) begin failures++; $display("FAIL sweep_data n=%0d got=%0d exp=%0d", n, o_data, e.data); end
      checks++; if (o_err !== e.err) begin failures++; $display("FAIL sweep_err n=%0d got=%b exp=%b", n, o_err, e.err); end
      checks++; if (o_lat !== e.lat) begin failures++; $display("FAIL sweep_lat n=%0d got=%0d exp=%0d", n, o_lat, e.lat); end
      checks++; if (o_nxt_valid !== 1'b0) begin failures++; $display("FAIL sweep_pulse n=%0d got=%b exp=0", n, o_nxt_valid); end
    end
  endtask

  task automatic test_non_fib;
    exp_t        e;
    logic [31:0] vals[5];
    vals = '{32'd4, 32'd100, 32'd0, 32'hFFFF_FFFF, 32'd2971215074};
    sb.push_back('{data: 32'd4,  err: 1'b1, lat: 5});
    sb.push_back('{data: 32'd11, err: 1'b1, lat: 12});
    sb.push_back('{data: 32'd0,  err: 1'b1, lat: 1});
    sb.push_back('{data: 32'd47, err: 1'b1, lat: 47});
    sb.push_back('{data: 32'd47, err: 1'b1, lat: 47});
    foreach (vals[i]) begin
      run_req(vals[i], 1'b0, 32'd0);
      e = sb.pop_front();
      checks++; if (o_data !== e.data) begin failures++; $display("FAIL nonfib_data v=%0d got=%0d exp=%0d", vals[i], o_data, e.data); end
      checks++; if (o_err !== e.err) begin failures++; $display("FAIL nonfib_err v=%0d got=%b exp=%b", vals[i], o_err, e.err); end
      checks++; if (o_lat !== e.lat) begin failures++; $display("FAIL nonfib_lat v=%0d got=%0d exp=%0d", vals[i], o_lat, e.lat); end
    end
  endtask

  task automatic test_handshake;
    exp_t e;
    sb.push_back('{data: 32'd7, err: 1'b0, lat: 7});
    run_req(32'd13, 1'b1, 32'd7);
    e = sb.pop_front();
    checks++; if (o_rdy_seen !== 1'b0) begin failures++; $display("FAIL hs_ready_calc got=%b exp=0", o_rdy_seen); end
    checks++; if (o_data !== e.data) begin failures++; $display("FAIL hs_data got=%0d exp=%0d", o_data, e.data); end
    checks++; if (o_err !== e.err) begin failures++; $display("FAIL hs_err got=%b exp=%b", o_err, e.err); end
    checks++; if (o_lat !== e.lat) begin failures++; $display("FAIL hs_lat got=%0d exp=%0d", o_lat, e.lat); end
  endtask

  task automatic test_back_to_back;
    exp_t        e;
    logic [31:0] v;
    for (int i = 0; i < 8; i++) begin
      v = (i < 4) ? 32'($urandom_range(0, 300)) : 32'($urandom_range(0, 50_000_000));
      sb.push_back(model({32'd0, v}));
      run_req(v, 1'b0, 32'd0);
      e = sb.pop_front();
      checks++; if (o_wait !== 0) begin failures++; $display("FAIL b2b_wait v=%0d got=%0d exp=0", v, o_wait); end
      checks++; if (o_data !== e.data) begin failures++; $display("FAIL b2b_data v=%0d got=%0d exp=%0d", v, o_data, e.data); end
      checks++; if (o_err !== e.err) begin failures++; $display("FAIL b2b_err v=%0d got=%b exp=%b", v, o_err, e.err); end
      checks++; if (o_lat !== e.lat) begin failures++; $display("FAIL b2b_lat v=%0d got=%0d exp=%0d", v, o_lat, e.lat); end
    end
  endtask

  task automatic test_reset_abort;
    exp_t e;
    int   n_wait, n_valid;
    n_wait = 0;
    @(negedge CLK);
    while (ASI_READY !== 1'b1 && n_wait < 100) begin
      @(negedge CLK);
      n_wait++;
    end
    ASI_VALID = 1'b1;
    ASI_DATA  = fib_tab[40][31:0];
    @(negedge CLK);
    ASI_VALID = 1'b0;
    repeat (10) @(negedge CLK);
    RESET_n = 1'b0;
    @(posedge CLK); #1;
    checks++; if (ASO_VALID !== 1'b0) begin failures++; $display("FAIL abort_valid got=%b exp=0", ASO_VALID); end
    checks++; if (ASO_DATA !== 32'd0) begin failures++; $display("FAIL abort_data got=%0d exp=0", ASO_DATA); end
    checks++; if (ASO_ERROR !== 1'b0) begin failures++; $display("FAIL abort_error got=%b exp=0", ASO_ERROR); end
    checks++; if (ASI_READY !== 1'b0) begin failures++; $display("FAIL abort_ready got=%b exp=0", ASI_READY); end
    @(negedge CLK); RESET_n = 1'b1;
    n_valid = 0;
    repeat (50) begin
      @(posedge CLK); #1;
      if (ASO_VALID === 1'b1) n_valid++;
    end
    checks++; if (n_valid !== 0) begin failures++; $display("FAIL abort_no_result got=%0d exp=0", n_valid); end
    sb.push_back('{data: 32'd6, err: 1'b0, lat: 6});
    run_req(32'd8, 1'b0, 32'd0);
    e = sb.pop_front();
    checks++; if (o_data !== e.data) begin failures++; $display("FAIL abort_next_data got=%0d exp=%0d", o_data, e.data); end
    checks++; if (o_err !== e.err) begin failures++; $display("FAIL abort_next_err got=%b exp=%b", o_err, e.err); end
    checks++; if (o_lat !== e.lat) begin failures++; $display("FAIL abort_next_lat got=%0d exp=%0d", o_lat, e.lat); end
  endtask

  initial begin
    fib_tab[0] = 64'd0;
    fib_tab[1] = 64'd1;
    for (int i = 2; i <= 48; i++) fib_tab[i] = fib_tab[i-1] + fib_tab[i-2];
    test_reset();
    test_one();
    test_sweep();
    test_non_fib();
    test_handshake();
    test_back_to_back();
    test_reset_abort();
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

endmodule
